// File: rtl/sonar_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonar_pkg
// Brief    : Shared types and constants for the ultrasonic ranger scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam int          NUM_SENSORS  = 3;
    localparam logic [1:0]  SENSOR_FRONT = 2'd0;
    localparam logic [1:0]  SENSOR_LEFT  = 2'd1;
    localparam logic [1:0]  SENSOR_RIGHT = 2'd2;
    localparam logic [15:0] DIST_MAX     = 16'hFFFF;
    localparam logic [15:0] CM_SAT       = 16'hFFFE;

    function automatic logic [1:0] next_sensor(input logic [1:0] s);
        return (s == SENSOR_RIGHT) ? SENSOR_FRONT : s + 2'd1;
    endfunction

    function automatic logic [2:0] sensor_onehot(input logic [1:0] s);
        return 3'b001 << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonar_scheduler_echo_sync.sv
`default_nettype none
// ============================================================================
// Module   : echo_sync
// Brief    : 2-FF synchroniser for one echo line with registered rise/fall
//            pulses (three cycles from pin to pulse).
// Revision : 1.0 - initial release
// ============================================================================
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_echo,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/sonar_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sonar_scheduler
// Brief    : Round-robin trigger/echo timing for three ultrasonic rangers,
//            publishing one registered centimetre distance per sensor.
// Revision : 1.0 - initial release
// ============================================================================
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int TRIG_CYCLES    = 1250,
    parameter int CM_CYCLES      = 7250,
    parameter int TIMEOUT_CYCLES = 3750000,
    parameter int GAP_CYCLES     = 1250000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  echo,
    output logic [2:0]  trig,
    output logic [15:0] distance_front,
    output logic [15:0] distance_left,
    output logic [15:0] distance_right,
    output logic [2:0]  valid,
    output logic [2:0]  timeout,
    output logic [1:0]  active
);

    localparam logic [22:0] c_trig_last = 23'(TRIG_CYCLES - 1);
    localparam logic [22:0] c_gap_last  = 23'(GAP_CYCLES - 1);
    localparam logic [22:0] c_tmo_last  = 23'(TIMEOUT_CYCLES - 1);
    localparam logic [12:0] c_cm_last   = 13'(CM_CYCLES - 1);

    logic [2:0]  w_rise;
    logic [2:0]  w_fall;
    logic        w_rise_act;
    logic        w_fall_act;

    state_t      r_state;
    logic [1:0]  r_active;
    logic [2:0]  r_trig;
    logic [2:0]  r_valid;
    logic [2:0]  r_timeout;
    logic [15:0] r_dist [NUM_SENSORS];
    logic [22:0] r_phase_cnt;
    logic [22:0] r_tmo_cnt;
    logic [12:0] r_presc;
    logic [15:0] r_cm;

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_sync
        echo_sync u_echo_sync (
            .clk    (clk),
            .reset  (reset),
            .i_echo (echo[i]),
            .o_rise (w_rise[i]),
            .o_fall (w_fall[i])
        );
    end

    assign w_rise_act = w_rise[r_active];
    assign w_fall_act = w_fall[r_active];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_active    <= SENSOR_FRONT;
            r_trig      <= '0;
            r_valid     <= '0;
            r_timeout   <= '0;
            r_phase_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_presc     <= '0;
            r_cm        <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_dist[i] <= DIST_MAX;
            end
        end else begin
            r_valid <= '0;
            if (r_state != IDLE && !enable) begin
                // Abort: results and the serviced sensor are kept for resume.
                r_state     <= IDLE;
                r_trig      <= '0;
                r_phase_cnt <= '0;
                r_tmo_cnt   <= '0;
                r_presc     <= '0;
                r_cm        <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (enable) begin
                            r_state     <= TRIG;
                            r_trig      <= sensor_onehot(r_active);
                            r_phase_cnt <= '0;
                        end
                    end
                    TRIG: begin
                        if (r_phase_cnt == c_trig_last) begin
                            r_state     <= WAIT_ECHO;
                            r_trig      <= '0;
                            r_phase_cnt <= '0;
                            r_tmo_cnt   <= '0;
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 23'd1;
                        end
                    end
                    WAIT_ECHO: begin
                        if (w_rise_act) begin
                            // The rise cycle itself is the first cycle of echo width.
                            r_state   <= MEASURE;
                            r_tmo_cnt <= r_tmo_cnt + 23'd1;
                            r_presc   <= (c_cm_last == 13'd0) ? 13'd0 : 13'd1;
                            r_cm      <= (c_cm_last == 13'd0) ? 16'd1 : 16'd0;
                        end else if (r_tmo_cnt == c_tmo_last) begin
                            r_state           <= GAP;
                            r_phase_cnt       <= '0;
                            r_dist[r_active]  <= DIST_MAX;
                            r_timeout[r_active] <= 1'b1;
                            r_valid           <= sensor_onehot(r_active);
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 23'd1;
                        end
                    end
                    MEASURE: begin
                        if (w_fall_act) begin
                            r_state             <= GAP;
                            r_phase_cnt         <= '0;
                            r_dist[r_active]    <= r_cm;
                            r_timeout[r_active] <= 1'b0;
                            r_valid             <= sensor_onehot(r_active);
                        end else if (r_tmo_cnt >= c_tmo_last) begin
                            r_state             <= GAP;
                            r_phase_cnt         <= '0;
                            r_dist[r_active]    <= DIST_MAX;
                            r_timeout[r_active] <= 1'b1;
                            r_valid             <= sensor_onehot(r_active);
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 23'd1;
                            if (r_presc == c_cm_last) begin
                                r_presc <= '0;
                                if (r_cm != CM_SAT) begin
                                    r_cm <= r_cm + 16'd1;
                                end
                            end else begin
                                r_presc <= r_presc + 13'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (r_phase_cnt == c_gap_last) begin
                            r_state     <= TRIG;
                            r_phase_cnt <= '0;
                            r_tmo_cnt   <= '0;
                            r_presc     <= '0;
                            r_cm        <= '0;
                            r_active    <= next_sensor(r_active);
                            r_trig      <= sensor_onehot(next_sensor(r_active));
                        end else begin
                            r_phase_cnt <= r_phase_cnt + 23'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_trig  <= '0;
                    end
                endcase
            end
        end
    end

    assign trig           = r_trig;
    assign valid          = r_valid;
    assign timeout        = r_timeout;
    assign active         = r_active;
    assign distance_front = r_dist[SENSOR_FRONT];
    assign distance_left  = r_dist[SENSOR_LEFT];
    assign distance_right = r_dist[SENSOR_RIGHT];

endmodule
`default_nettype wire

// File: tb/tb_sonar_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sonar_scheduler
// Brief    : Self-checking bench for sonar_scheduler with scaled timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sonar_scheduler;
    import sonar_pkg::*;

    localparam int P_TRIG = 5;
    localparam int P_CM   = 10;
    localparam int P_TMO  = 600;
    localparam int P_GAP  = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  echo;
    logic [2:0]  trig;
    logic [15:0] distance_front;
    logic [15:0] distance_left;
    logic [15:0] distance_right;
    logic [2:0]  valid;
    logic [2:0]  timeout;
    logic [1:0]  active;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_dist [3];
    logic [2:0]  m_tmo;
    int          m_act;

    sonar_scheduler #(
        .TRIG_CYCLES    (P_TRIG),
        .CM_CYCLES      (P_CM),
        .TIMEOUT_CYCLES (P_TMO),
        .GAP_CYCLES     (P_GAP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .echo           (echo),
        .trig           (trig),
        .distance_front (distance_front),
        .distance_left  (distance_left),
        .distance_right (distance_right),
        .valid          (valid),
        .timeout        (timeout),
        .active         (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] dist_of(input int s);
        case (s)
            0:       return distance_front;
            1:       return distance_left;
            default: return distance_right;
        endcase
    endfunction

    // Waits for the next trigger pulse, checks its selection and width; returns
    // on the first sample with the trigger low (the trigger-fall cycle).
    task automatic wait_trig(input int exp_wait);
        int n;
        int hi;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (trig === 3'b000 && n < 5000);
        if (exp_wait >= 0) check("trig_delay", n, exp_wait);
        check("trig_sel", {29'd0, trig}, {29'd0, 3'(1 << m_act)});
        check("active", {30'd0, active}, m_act);
        hi = 1;
        while (hi < 5000) begin
            @(negedge clk);
            if (trig !== 3'b000) hi++;
            else break;
        end
        check("trig_width", hi, P_TRIG);
    endtask

    // mode 0: echo pulse of width w starting d cycles after trigger fall;
    // mode 1: echo never rises; mode 2: echo already high before the trigger.
    task automatic measure(input int mode, input int d, input int w, input int exp_wait);
        int          exp_n;
        int          first_n;
        logic [2:0]  first_v;
        logic [15:0] exp_d;
        logic        exp_t;
        if (mode == 2) echo[m_act] = 1'b1;
        wait_trig(exp_wait);
        if (mode == 0 && d + w + 4 <= P_TMO) begin
            exp_n = d + w + 4;
            exp_d = 16'(w / P_CM);
            exp_t = 1'b0;
        end else begin
            exp_n = P_TMO;
            exp_d = DIST_MAX;
            exp_t = 1'b1;
        end
        first_n = -1;
        first_v = '0;
        for (int n = 0; n <= exp_n + 4 && first_n < 0; n++) begin
            if (valid !== 3'b000) begin
                first_n = n;
                first_v = valid;
                check("dist_new", {16'd0, dist_of(m_act)}, {16'd0, exp_d});
            end else if (n == exp_n - 1) begin
                check("dist_stable", {16'd0, dist_of(m_act)}, {16'd0, m_dist[m_act]});
            end
            if (mode == 0) echo[m_act] = (n >= d && n < d + w);
            if (first_n < 0) @(negedge clk);
        end
        echo[m_act] = 1'b0;
        check("valid_time", first_n, exp_n);
        check("valid_sel", {29'd0, first_v}, {29'd0, 3'(1 << m_act)});
        m_dist[m_act] = exp_d;
        m_tmo[m_act]  = exp_t;
        check("timeout_vec", {29'd0, timeout}, {29'd0, m_tmo});
        for (int s = 0; s < 3; s++) begin
            if (s != m_act) check("dist_other", {16'd0, dist_of(s)}, {16'd0, m_dist[s]});
        end
        m_act = (m_act + 1) % 3;
    endtask

    initial begin
        logic seen_valid;
        reset  = 1'b1;
        enable = 1'b0;
        echo   = 3'b000;
        m_tmo  = 3'b000;
        m_act  = 0;
        for (int s = 0; s < 3; s++) m_dist[s] = DIST_MAX;

        repeat (3) @(negedge clk);
        check("rst_front", {16'd0, distance_front}, {16'd0, DIST_MAX});
        check("rst_left",  {16'd0, distance_left},  {16'd0, DIST_MAX});
        check("rst_right", {16'd0, distance_right}, {16'd0, DIST_MAX});
        check("rst_trig",  {29'd0, trig}, 0);
        check("rst_valid", {29'd0, valid}, 0);
        check("rst_tmo",   {29'd0, timeout}, 0);
        check("rst_active", {30'd0, active}, 0);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        measure(0, 3, 130, 1);          // front: 13 cm
        measure(1, 0, 0, P_GAP);        // left: silent -> timeout
        measure(2, 0, 0, P_GAP);        // right: stuck high -> timeout

        repeat (8) begin
            int d;
            int w;
            d = $urandom_range(0, 40);
            w = $urandom_range(1, P_TMO);
            measure(0, d, w, P_GAP);
        end
        while (m_act != 0) measure(0, 2, $urandom_range(1, 300), P_GAP);

        // Abort in MEASURE on the front sensor.
        wait_trig(P_GAP);
        for (int n = 0; n < 30; n++) begin
            echo[0] = (n >= 2);
            @(negedge clk);
        end
        enable     = 1'b0;
        seen_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (valid !== 3'b000) seen_valid = 1'b1;
        end
        check("abort_valid", {31'd0, seen_valid}, 0);
        check("abort_trig", {29'd0, trig}, 0);
        check("abort_front", {16'd0, distance_front}, {16'd0, m_dist[0]});
        check("abort_active", {30'd0, active}, 0);
        echo[0] = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;

        measure(0, 10, P_TMO - 14, 1);       // fall on the timeout cycle: measured
        measure(0, 10, P_TMO - 13, P_GAP);   // one cycle later: timeout

        // Asynchronous reset during a trigger pulse.
        repeat (P_GAP + 2) @(negedge clk);
        check("pre_rst_trig", {29'd0, trig}, {29'd0, 3'(1 << m_act)});
        #2 reset = 1'b1;
        #1;
        check("arst_trig", {29'd0, trig}, 0);
        check("arst_front", {16'd0, distance_front}, {16'd0, DIST_MAX});
        check("arst_left", {16'd0, distance_left}, {16'd0, DIST_MAX});
        check("arst_tmo", {29'd0, timeout}, 0);
        check("arst_active", {30'd0, active}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
